// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM SRAM arbiter.
// FSM states, owner codes and the inactive strobe level live here so the top and bench agree.
package mem_arbiter_pkg;

    localparam logic [1:0] ArbIdle   = 2'd0;
    localparam logic [1:0] ArbAccess = 2'd1;
    localparam logic [1:0] ArbDone   = 2'd2;

    localparam logic ArbOwnIf  = 1'b0;
    localparam logic ArbOwnMem = 1'b1;

    localparam int   WaitCyclesDflt = 1;
    localparam logic StrobeOff      = 1'b1;

    // Terminal value of the 3-bit ACCESS counter for a given strobe width.
    function automatic logic [2:0] last_cnt(input int wait_cycles);
        return 3'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/mem_arb_ifbuf.sv
// mem_arb_ifbuf: one-entry {valid, addr, data} buffer of the last completed IF read.
// Latency: lookup is combinational; fill and invalidate take effect at the next edge.
// Backpressure: none; it only shadows traffic the arbiter has already completed.
module mem_arb_ifbuf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_vld,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_dat,
    input  logic              inval,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_dat
);

    logic              buf_vld;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_dat;

    // Fill happens on the last ACCESS cycle and invalidation in IDLE, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_dat  <= '0;
        end else if (inval) begin
            buf_vld <= 1'b0;
        end else if (fill_vld) begin
            buf_vld  <= 1'b1;
            buf_addr <= fill_addr;
            buf_dat  <= fill_dat;
        end
    end

    assign hit     = buf_vld && (buf_addr == lookup_addr);
    assign hit_dat = buf_dat;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (MEM over IF) owner of the shared SRAM; optional fetch buffer under MEM_ARB_IFBUF_EN.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the request is sampled in IDLE (next cycle on a fetch-buffer hit).
// Backpressure: requesters hold req until their ready pulse; stall_req_o freezes the pipeline meanwhile.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = WaitCyclesDflt,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_wdata_oe_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic              stall_req_o
);

    localparam logic [2:0] CntLast = last_cnt(WAIT_CYCLES);

    logic [1:0]        state;
    logic              owner;
    logic              we_q;
    logic [2:0]        cnt;
    logic              access_last;
    logic              if_buf_hit;
    logic [DATA_W-1:0] if_buf_dat;

    assign access_last = (state == ArbAccess) && (cnt == CntLast);

`ifdef MEM_ARB_IFBUF_EN
    logic buf_hit;

    mem_arb_ifbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ifbuf (
        .clk         (clk),
        .rst         (rst),
        .fill_vld    (access_last && (owner == ArbOwnIf)),
        .fill_addr   (ram_addr_o),
        .fill_dat    (ram_rdata_i),
        .inval       ((state == ArbIdle) && mem_req_i && mem_we_i),
        .lookup_addr (if_addr_i),
        .hit         (buf_hit),
        .hit_dat     (if_buf_dat)
    );

    assign if_buf_hit = if_req_i && buf_hit;
`else
    assign if_buf_hit = 1'b0;
    assign if_buf_dat = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ArbIdle;
            owner          <= ArbOwnIf;
            we_q           <= 1'b0;
            cnt            <= '0;
            ram_addr_o     <= '0;
            ram_wdata_o    <= '0;
            ram_wdata_oe_o <= 1'b0;
            ram_ce_n_o     <= StrobeOff;
            ram_oe_n_o     <= StrobeOff;
            ram_we_n_o     <= StrobeOff;
            if_ready_o     <= 1'b0;
            mem_ready_o    <= 1'b0;
            if_rdata_o     <= '0;
            mem_rdata_o    <= '0;
        end else begin
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            case (state)
                ArbIdle: begin
                    // MEM holds the older instruction, so it always wins a tie.
                    if (mem_req_i) begin
                        state          <= ArbAccess;
                        owner          <= ArbOwnMem;
                        we_q           <= mem_we_i;
                        cnt            <= '0;
                        ram_addr_o     <= mem_addr_i;
                        ram_wdata_o    <= mem_wdata_i;
                        ram_wdata_oe_o <= mem_we_i;
                        ram_ce_n_o     <= 1'b0;
                        ram_oe_n_o     <= mem_we_i;
                        ram_we_n_o     <= ~mem_we_i;
                    end else if (if_buf_hit) begin
                        // Strobes stay off; DONE only delivers the buffered word.
                        state      <= ArbDone;
                        owner      <= ArbOwnIf;
                        we_q       <= 1'b0;
                        if_ready_o <= 1'b1;
                        if_rdata_o <= if_buf_dat;
                    end else if (if_req_i) begin
                        state      <= ArbAccess;
                        owner      <= ArbOwnIf;
                        we_q       <= 1'b0;
                        cnt        <= '0;
                        ram_addr_o <= if_addr_i;
                        ram_ce_n_o <= 1'b0;
                        ram_oe_n_o <= 1'b0;
                    end
                end
                ArbAccess: begin
                    if (cnt == CntLast) begin
                        state      <= ArbDone;
                        ram_oe_n_o <= StrobeOff;
                        ram_we_n_o <= StrobeOff;
                        if (owner == ArbOwnMem) begin
                            mem_ready_o <= 1'b1;
                            if (!we_q) begin
                                mem_rdata_o <= ram_rdata_i;
                            end
                        end else begin
                            if_ready_o <= 1'b1;
                            if_rdata_o <= ram_rdata_i;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ArbDone: begin
                    // ce_n, address and data drive were held through DONE for write hold time.
                    state          <= ArbIdle;
                    ram_ce_n_o     <= StrobeOff;
                    ram_wdata_oe_o <= 1'b0;
                end
                default: begin
                    state <= ArbIdle;
                end
            endcase
        end
    end

    assign stall_req_o = ~rst & ((if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM model, scoreboard of expected completions, W=1 and W=3 instances.
// Define MEM_ARB_IFBUF_EN for the bench and RTL together to exercise the fetch buffer.
module tb_mem_arbiter;

    localparam int W = 1;
`ifdef MEM_ARB_IFBUF_EN
    localparam bit IFBUF = 1'b1;
`else
    localparam bit IFBUF = 1'b0;
`endif

    typedef struct {
        bit          is_mem;
        bit          is_store;
        logic [15:0] addr;
        logic [15:0] dat;
        logic        ce_exp;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_ready, mem_req, mem_we, mem_ready, stall_req;
    logic [15:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_wdata_oe, ram_ce_n, ram_oe_n, ram_we_n;

    logic        w3_if_req, w3_if_ready, w3_mem_ready, w3_stall;
    logic [15:0] w3_if_addr, w3_if_rdata, w3_mem_rdata, w3_ram_addr, w3_ram_wdata, w3_ram_rdata;
    logic        w3_wdata_oe, w3_ce_n, w3_oe_n, w3_we_n;

    logic [15:0] sram [0:65535];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   oe_lo = 0;
    int   we_lo = 0;
    exp_t sb_q[$];

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wdata_oe_o(ram_wdata_oe),
        .ram_rdata_i(ram_rdata), .ram_ce_n_o(ram_ce_n), .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n),
        .stall_req_o(stall_req)
    );

    mem_arbiter #(.WAIT_CYCLES(3), .ADDR_W(16), .DATA_W(16)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_i(w3_if_req), .if_addr_i(w3_if_addr), .if_rdata_o(w3_if_rdata), .if_ready_o(w3_if_ready),
        .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(16'h0000), .mem_wdata_i(16'h0000),
        .mem_rdata_o(w3_mem_rdata), .mem_ready_o(w3_mem_ready),
        .ram_addr_o(w3_ram_addr), .ram_wdata_o(w3_ram_wdata), .ram_wdata_oe_o(w3_wdata_oe),
        .ram_rdata_i(w3_ram_rdata), .ram_ce_n_o(w3_ce_n), .ram_oe_n_o(w3_oe_n), .ram_we_n_o(w3_we_n),
        .stall_req_o(w3_stall)
    );

    assign ram_rdata    = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] : 16'hDEAD;
    assign w3_ram_rdata = (!w3_ce_n && !w3_oe_n) ? sram[w3_ram_addr] : 16'hDEAD;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ram_ce_n && !ram_we_n && ram_wdata_oe) sram[ram_addr] <= ram_wdata;
    end

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h4A05 : (a ^ 16'hA5C3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input bit is_mem, input bit is_store, input logic [15:0] a,
                        input logic [15:0] d, input logic ce_exp, input int due);
        exp_t e;
        e.is_mem = is_mem; e.is_store = is_store; e.addr = a; e.dat = d;
        e.ce_exp = ce_exp; e.due = due;
        sb_q.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!ram_oe_n) oe_lo++;
        if (!ram_we_n) we_lo++;
        if (if_ready || mem_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("ready_owner", {30'd0, if_ready, mem_ready}, e.is_mem ? 32'd1 : 32'd2);
                chk("latency", cyc, e.due);
                chk("done_strobes", {29'd0, ram_ce_n, ram_oe_n, ram_we_n}, {29'd0, e.ce_exp, 2'b11});
                if (!e.ce_exp) chk("done_addr", ram_addr, e.addr);
                if (e.is_store) begin
                    chk("store_hold_data", ram_wdata, e.dat);
                    chk("store_hold_oe", ram_wdata_oe, 1);
                end else begin
                    chk("rdata", e.is_mem ? mem_rdata : if_rdata, e.dat);
                end
            end
        end
    end

    task automatic run_if(input logic [15:0] a);
        bit done = 1'b0;
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (if_ready) done = 1'b1;
            else chk("stall_if_wait", stall_req, 1);
        end
        if (!done) chk("timeout_if", if_ready, 1);
        if_req = 1'b0;
    endtask

    task automatic run_mem(input logic we, input logic [15:0] a, input logic [15:0] d);
        bit done = 1'b0;
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mem_ready) done = 1'b1;
            else chk("stall_mem_wait", stall_req, 1);
        end
        if (!done) chk("timeout_mem", mem_ready, 1);
        mem_req = 1'b0; mem_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ld_tab [3];
        int n;
        ld_tab[0] = 16'h0100; ld_tab[1] = 16'h7FFF; ld_tab[2] = 16'hFFFF;
        for (int i = 0; i < 65536; i++) sram[i] = init_val(16'(i));
        rst = 1'b1;
        if_req = 1'b1; if_addr = 16'h0000;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
        w3_if_req = 1'b0; w3_if_addr = 16'h0000;
        idle(3);
        // Reset state, with a request pending to show stall is masked.
        chk("rst_stall", stall_req, 0);
        chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_wdata_oe}, 4'b1110);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_ready", {if_ready, mem_ready}, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        chk("rst_w3", {w3_ce_n, w3_oe_n, w3_we_n, w3_wdata_oe, w3_if_ready, w3_mem_ready, w3_stall}, 7'b1110000);
        chk("rst_w3_bus", {w3_ram_addr, w3_ram_wdata, w3_if_rdata, w3_mem_rdata}, 0);
        if_req = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(2);

        // IF read, 1-cycle strobe.
        oe_lo = 0; we_lo = 0;
        push(0, 0, 16'h0010, 16'h4A05, 1'b0, cyc + 1 + W);
        run_if(16'h0010);
        idle(1);
        chk("if_stall_after", stall_req, 0);
        chk("if_oe_cycles", oe_lo, W);
        chk("if_we_cycles", we_lo, 0);

        // MEM store then read-back.
        idle(1);
        oe_lo = 0; we_lo = 0;
        push(1, 1, 16'h8000, 16'h1234, 1'b0, cyc + 1 + W);
        run_mem(1'b1, 16'h8000, 16'h1234);
        chk("st_we_cycles", we_lo, W);
        chk("st_oe_cycles", oe_lo, 0);
        idle(1);
        push(1, 0, 16'h8000, 16'h1234, 1'b0, cyc + 1 + W);
        run_mem(1'b0, 16'h8000, 16'h0000);
        idle(1);

        // Collision: MEM first, IF W+2 cycles later.
        push(1, 0, 16'h8001, init_val(16'h8001), 1'b0, cyc + 1 + W);
        push(0, 0, 16'h0020, init_val(16'h0020), 1'b0, cyc + 1 + W + W + 2);
        fork
            run_mem(1'b0, 16'h8001, 16'h0000);
            run_if(16'h0020);
        join
        idle(1);

        // Assorted loads.
        for (int i = 0; i < 3; i++) begin
            push(1, 0, ld_tab[i], init_val(ld_tab[i]), 1'b0, cyc + 1 + W);
            run_mem(1'b0, ld_tab[i], 16'h0000);
            idle(1);
        end

        // WAIT_CYCLES=3 read.
        w3_if_req = 1'b1; w3_if_addr = 16'h0040; n = 0; oe_lo = 0;
        while (!w3_if_ready && n < 40) begin
            @(negedge clk);
            n++;
            if (!w3_oe_n) oe_lo++;
        end
        chk("w3_latency", n, 4);
        chk("w3_oe_cycles", oe_lo, 3);
        chk("w3_rdata", w3_if_rdata, init_val(16'h0040));
        w3_if_req = 1'b0;
        idle(2);

        // Reset in the middle of a store.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8100; mem_wdata = 16'hBEEF;
        @(negedge clk);
        chk("mid_store_we", ram_we_n, 0);
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_wdata_oe}, 4'b1110);
        chk("abort_ready", {if_ready, mem_ready}, 0);
        chk("abort_addr", ram_addr, 0);
        rst = 1'b0;
        idle(1);
        push(0, 0, 16'h0020, init_val(16'h0020), 1'b0, cyc + 1 + W);
        run_if(16'h0020);
        idle(1);

        // Repeated fetch: buffer hit when enabled, store forces the SRAM path again.
        push(0, 0, 16'h0030, init_val(16'h0030), 1'b0, cyc + 1 + W);
        run_if(16'h0030);
        idle(1);
        oe_lo = 0;
        push(0, 0, 16'h0030, init_val(16'h0030), IFBUF, IFBUF ? cyc + 1 : cyc + 1 + W);
        run_if(16'h0030);
        chk("refetch_oe_cycles", oe_lo, IFBUF ? 0 : W);
        idle(1);
        push(1, 1, 16'h9000, 16'h5555, 1'b0, cyc + 1 + W);
        run_mem(1'b1, 16'h9000, 16'h5555);
        idle(1);
        oe_lo = 0;
        push(0, 0, 16'h0030, init_val(16'h0030), 1'b0, cyc + 1 + W);
        run_if(16'h0030);
        chk("post_store_oe_cycles", oe_lo, W);
        idle(3);

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single shared 16-bit SRAM between instruction fetch (IF) and the MEM stage's load/store port. It sequences the SRAM control strobes through a small FSM and returns a one-cycle ready pulse with read data. It raises stall_req_o to the pipeline ctrl block while any requester is waiting. It sits between the IF/MEM stages and the top-level SRAM pins; tristate handling of the data bus stays in the top level.

Parameters:
WAIT_CYCLES, 1, number of cycles the SRAM strobe (oe_n/we_n) is held low per access; legal range 1..7
ADDR_W, 16, address width (InstAddrBus/DataBus width)
DATA_W, 16, data width

Ports:
clk  in  1  system clock, all state changes on rising edge
rst  in  1  synchronous reset, active-high (RstEnable = 1)
if_req_i  in  1  IF fetch request; held until if_ready_o
if_addr_i  in  ADDR_W  fetch address (PC)
if_rdata_o  out  DATA_W  fetched instruction, valid while if_ready_o=1
if_ready_o  out  1  one-cycle completion pulse for IF
mem_req_i  in  1  MEM-stage request; held until mem_ready_o
mem_we_i  in  1  1 = store, 0 = load
mem_addr_i  in  ADDR_W  data address
mem_wdata_i  in  DATA_W  store data
mem_rdata_o  out  DATA_W  load data, valid while mem_ready_o=1
mem_ready_o  out  1  one-cycle completion pulse for MEM
ram_addr_o  out  ADDR_W  SRAM address
ram_wdata_o  out  DATA_W  SRAM write data
ram_wdata_oe_o  out  1  top-level drives the data bus when 1
ram_rdata_i  in  DATA_W  SRAM read data
ram_ce_n_o  out  1  chip enable, active-low
ram_oe_n_o  out  1  output enable, active-low
ram_we_n_o  out  1  write enable, active-low
stall_req_o  out  1  to ctrl: pipeline must hold

Behaviour:
- FSM states: IDLE, ACCESS, DONE. State and owner are registered. Owner is OWN_IF or OWN_MEM.
- Reset (rst=1 at an edge): state goes to IDLE and the in-flight access is abandoned, including a partial write. Registered outputs become: ram_ce_n/oe_n/we_n=1, ram_wdata_oe=0, ram_addr=0, ram_wdata=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0. stall_req_o is combinational and reads 0 while rst=1.
- IDLE: when any request is present, latch the owner, address, we and wdata, then go to ACCESS. Fixed priority is MEM over IF: MEM holds the older instruction, so IF is starved only while MEM keeps requesting. With no request, stay in IDLE with all strobes high.
- ACCESS: lasts WAIT_CYCLES cycles, counted by a 3-bit counter. ce_n=0 throughout.
  - Read: oe_n=0.
  - Write: we_n=0 and wdata_oe=1.
  - On the last ACCESS cycle, ram_rdata_i is registered into the owner's rdata register (reads only). Then go to DONE.
- DONE, exactly 1 cycle:
  - Strobes: we_n=1 and oe_n=1. ce_n=0, address and wdata_oe stay held, giving write data hold time.
  - The owner's ready pulse is 1 and rdata is valid.
  - Next state is IDLE unconditionally.
- Latency: a request sampled in IDLE at edge t completes with ready high in cycle t+WAIT_CYCLES+1. Throughput is 1 access per WAIT_CYCLES+2 cycles.
- Requesters must keep req/addr/wdata stable until ready. The arbiter uses only its latched copies after IDLE, so changes mid-access are ignored.
- Simultaneous requests: MEM is served first. IF is taken at the next IDLE if still requesting.
- rdata registers hold their last value between accesses. Ready is never asserted for a non-owner.
- stall_req_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o).
- Address wrap is not applicable; the address passes through unmodified.

Optional Feature:
MEM_ARB_IFBUF_EN:
- With the macro defined, a one-entry fetch buffer holds {valid, addr, data} of the last completed IF read.
- In IDLE, an if_req_i matching the buffer address with valid=1 and no MEM request goes directly to DONE: if_ready one cycle later, no SRAM strobes.
- Any MEM store invalidates the buffer when it enters ACCESS. rst clears valid.
- Without the macro, every fetch takes the SRAM path; the buffer and its logic are absent.

Decomposition:
- defines.v gets the state encodings (ArbIdle, ArbAccess, ArbDone), the owner encodings (ArbOwnIf, ArbOwnMem), the WAIT_CYCLES default, and a StrobeOff=1'b1 constant.
- One natural sub-module, mem_arb_ifbuf (the fetch buffer), is instantiated only under MEM_ARB_IFBUF_EN.

Test Plan:
1. IF read: WAIT_CYCLES=1, if_req at addr 0x0010, SRAM[0x0010]=0x4A05 -> oe_n low for 1 cycle; if_ready=1 with if_rdata=0x4A05 two cycles after sampling; stall_req low the next cycle.
2. MEM store: addr 0x8000, wdata 0x1234 -> we_n low for WAIT_CYCLES cycles, then high in DONE with addr/data still driven; mem_ready pulse; a read-back returns 0x1234.
3. Collision: if_req(0x0020) and mem_req load(0x8001) raised in the same cycle -> MEM completes first, IF completes WAIT_CYCLES+2 cycles later; stall_req stays high throughout.
4. WAIT_CYCLES=3 read -> ACCESS lasts 3 cycles; ready appears 4 cycles after sampling.
5. rst asserted during a write's ACCESS -> next cycle all strobes high, state IDLE, no ready pulse; a new request is accepted normally afterwards.
6. (MEM_ARB_IFBUF_EN) two fetches of 0x0030 -> second completes in 1 cycle with no strobe; an intervening store to any address forces the SRAM path.
